uart_word_loader: RTL
=====================

# uart_word_loader

Byte-to-word program loader sitting directly downstream of the UART receiver. Consumes received bytes (one-cycle `data_ready` strobes with `data_out`), parses a length-prefixed frame, assembles little-endian 32-bit words and writes them sequentially into instruction/data memory. Signals completion so the core can be released from reset-hold and start execution.

## Interface
- `ADDR_WIDTH`, default 10: word-address width of the memory write port.
- `BASE_ADDR`, default 0: word address of the first word written.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `byte_in`  in  8  received byte; connects to UART `data_out`.
- `byte_valid`  in  1  byte strobe; connects to UART `data_ready`. Every cycle it is high counts as one byte.
- `mem_addr`  out  ADDR_WIDTH  word write address.
- `mem_wdata`  out  32  word write data.
- `mem_we`  out  1  write enable, one-cycle pulse per word.
- `busy`  out  1  frame in progress.
- `load_done`  out  1  one-cycle pulse at frame end.
- `load_err`  out  1  sticky checksum-mismatch flag; 0 unless the checksum feature is compiled in.

## Operation
- Frame format: `CNT_LO`, `CNT_HI` (16-bit word count N, little-endian), then 4·N data bytes, each word LSB first. With the checksum feature enabled, one trailing checksum byte follows.
- States:
  - `CNT_L`: reset state; the accepted byte becomes N[7:0]; go to `CNT_H`; clear `load_err`.
  - `CNT_H`: the accepted byte becomes N[15:8]. If N == 0, go to `CSUM` (checksum build) or finish (otherwise). If N != 0, go to `DATA`.
  - `DATA`: 2-bit byte index shifts the byte into lane `[8·i +: 8]`. On i == 3, issue a write and increment the word counter. After word N, go to `CSUM` or finish.
  - `CSUM`: compare the accepted byte with the running XOR; finish.
  - Finish: return to `CNT_L`.
- Word address = `BASE_ADDR` + word index, truncated to `ADDR_WIDTH` bits. It wraps modulo 2^ADDR_WIDTH, with no error.
- Word counter is 16 bits; the N comparison uses the full 16 bits.
- Running XOR covers data bytes only, not the header. It is reset at `CNT_L`.
- `byte_valid` low: no state change. No upstream backpressure exists; the block accepts a byte every cycle.
- Reset mid-frame:
  - All state returns to `CNT_L`.
  - The partial word is discarded.
  - No `mem_we` or `load_done` is emitted.

## Timing
- Reset values: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `busy`=0, `load_done`=0, `load_err`=0, state `CNT_L`.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid together in the cycle after the 4th byte of a word is sampled, for exactly one cycle.
- `mem_addr`/`mem_wdata` hold their last values after `mem_we` drops.
- `busy` rises in the cycle after `CNT_LO` is sampled. It falls in the same cycle that `load_done` pulses.
- `load_done` pulses in the cycle after the final frame byte is sampled. The final byte is the last data byte, the checksum byte, or `CNT_HI` when N=0 without checksum.
- When the last word completes the frame, `mem_we` and `load_done` are asserted in the same cycle.
- `load_err` updates in the same cycle as `load_done` and holds until the next `CNT_LO` is accepted.
- A new frame may start on the cycle immediately after the final byte.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - The frame carries a trailing XOR byte.
  - On mismatch, `load_err`=1 with `load_done`; words already written stay written.
  - For N=0 the expected checksum is 0x00.
- Undefined:
  - No `CSUM` state and no XOR logic.
  - `load_err` is tied to 0.
  - The frame ends on the last data byte.

## Test plan
- Bytes 01 00 EF BE AD DE, no checksum, `BASE_ADDR`=0 -> one `mem_we`, addr 0, data 0xDEADBEEF. `load_done` and `mem_we` in the same cycle. `busy` low afterwards.
- Bytes 00 00 -> no `mem_we`; `load_done` one cycle after the 2nd byte. With checksum: 00 00 00 -> `load_done`, `load_err`=0.
- N=3, 14 bytes on consecutive cycles (`byte_valid` held high), `BASE_ADDR`=0x10 -> writes at 0x10, 0x11, 0x12 with correct words. Writes are four cycles apart. The next frame is accepted immediately.
- `ADDR_WIDTH`=2, N=5 -> addresses 0, 1, 2, 3, 0; `load_done` after the fifth word.
- Checksum enabled: 01 00 11 22 33 44 44 -> 0x44332211 written, `load_err`=0. Same frame with a final byte of 45 -> `load_err`=1, cleared by the next `CNT_LO`.
- Reset pulsed after 2 data bytes of N=2 -> no `mem_we`, `busy`=0. Then a fresh frame 01 00 78 56 34 12 -> 0x12345678 at `BASE_ADDR`.

Source files
------------

// File: rtl/uart_word_loader.sv
// uart_word_loader: byte-to-word program loader fed directly by a UART receiver.
// Frame: CNT_LO, CNT_HI (16-bit word count N), then 4*N data bytes, LSB first per word.
// Each assembled word is written to BASE_ADDR + index, wrapping modulo 2^ADDR_WIDTH.
// Optional feature: define UART_LOADER_CHECKSUM_EN to add a trailing XOR byte over the
// data bytes. A mismatch raises the sticky o_load_err flag together with o_load_done.
// With the macro undefined there is no checksum state and o_load_err is tied low.
module uart_word_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_busy,
  output logic                  o_load_done,
  output logic                  o_load_err
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StCntL, StCntH, StData, StCsum} state_e;
`else
  typedef enum logic [1:0] {StCntL, StCntH, StData} state_e;
`endif

  state_e                r_state;
  logic [15:0]           r_cnt;        // word count N of the current frame
  logic [15:0]           r_word_idx;   // index of the word being assembled
  logic [1:0]            r_byte_idx;   // byte lane within the current word
  logic [23:0]           r_lanes;      // lower three bytes of the word in progress
  logic [ADDR_WIDTH-1:0] r_next_addr;  // address the next completed word goes to
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_busy;
  logic                  r_load_done;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            r_xor;        // running XOR of data bytes only
  logic                  r_load_err;
`endif

  logic [15:0] w_cnt_full;
  logic        w_last_word;

  // Full count as it will be once CNT_HI is taken, and last-word detection in DATA
  always_comb begin
    w_cnt_full  = {i_byte_in, r_cnt[7:0]};
    w_last_word = (r_word_idx == (r_cnt - 16'd1));
  end

  // Frame parser FSM with registered memory-write and status outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StCntL;
      r_cnt       <= 16'd0;
      r_word_idx  <= 16'd0;
      r_byte_idx  <= 2'd0;
      r_lanes     <= 24'd0;
      r_next_addr <= BaseAddr;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_xor       <= 8'd0;
      r_load_err  <= 1'b0;
`endif
    end else begin
      // Strobes default low; they pulse for exactly one cycle
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      if (i_byte_valid) begin
        case (r_state)
          StCntL: begin
            r_cnt       <= {8'h00, i_byte_in};
            r_word_idx  <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_next_addr <= BaseAddr;
            r_busy      <= 1'b1;
            r_state     <= StCntH;
`ifdef UART_LOADER_CHECKSUM_EN
            r_xor       <= 8'd0;
            r_load_err  <= 1'b0;
`endif
          end
          StCntH: begin
            r_cnt[15:8] <= i_byte_in;
            if (w_cnt_full == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              r_state     <= StCsum;
`else
              r_load_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= StCntL;
`endif
            end else begin
              r_state <= StData;
            end
          end
          StData: begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ i_byte_in;
`endif
            case (r_byte_idx)
              2'd0: r_lanes[7:0]   <= i_byte_in;
              2'd1: r_lanes[15:8]  <= i_byte_in;
              2'd2: r_lanes[23:16] <= i_byte_in;
              default: begin
                // Fourth byte completes the word: write it out this edge
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_next_addr;
                r_mem_wdata <= {i_byte_in, r_lanes};
                r_next_addr <= r_next_addr + AddrOne;
                r_word_idx  <= r_word_idx + 16'd1;
                if (w_last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
                  r_state     <= StCsum;
`else
                  r_load_done <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= StCntL;
`endif
                end
              end
            endcase
          end
`ifdef UART_LOADER_CHECKSUM_EN
          StCsum: begin
            r_load_err  <= (i_byte_in != r_xor);
            r_load_done <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= StCntL;
          end
`endif
          default: r_state <= StCntL;
        endcase
      end
    end
  end

  // Drive ports straight from registers
  always_comb begin
    o_mem_addr  = r_mem_addr;
    o_mem_wdata = r_mem_wdata;
    o_mem_we    = r_mem_we;
    o_busy      = r_busy;
    o_load_done = r_load_done;
`ifdef UART_LOADER_CHECKSUM_EN
    o_load_err  = r_load_err;
`else
    o_load_err  = 1'b0;
`endif
  end

endmodule
